// File: rtl/write_output_if.sv
`default_nettype none
// ============================================================================
//  Module      : write_output_if
//  Description : Frame-request, FFT result capture and result stream bundle
//                for the write_output block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface write_output_if #(
    parameter int WORDSIZE = 16
);
    logic                st_data;
    logic                in_valid;
    logic [WORDSIZE-1:0] fft_out0;
    logic [WORDSIZE-1:0] fft_out1;
    logic [WORDSIZE-1:0] fft_out2;
    logic [WORDSIZE-1:0] fft_out3;
    logic [WORDSIZE-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                wr_done;
    logic                wr_error;

    // Controller / upstream FFT / downstream sink side
    modport master (
        output st_data, in_valid, fft_out0, fft_out1, fft_out2, fft_out3, out_ready,
        input  out_data, out_valid, wr_done, wr_error
    );

    // write_output block side
    modport slave (
        input  st_data, in_valid, fft_out0, fft_out1, fft_out2, fft_out3, out_ready,
        output out_data, out_valid, wr_done, wr_error
    );
endinterface
`default_nettype wire

// File: rtl/write_output.sv
`default_nettype none
// ============================================================================
//  Module      : write_output
//  Description : Captures four FFT result words per cycle into a frame buffer,
//                then streams the frame out one word per cycle (natural or
//                bit-reversed address order) and reports completion with a
//                level handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module write_output #(
    parameter int WORDSIZE   = 16,
    parameter int NUMSAMPLES = 32,
    parameter int ADDRBITS   = 5,
    parameter int BITREV     = 0
) (
    input  wire logic      clk,
    input  wire logic      rst,
    write_output_if.slave  bus
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_DRAIN   = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    localparam logic [ADDRBITS-3:0] c_LAST_GRP  = (ADDRBITS-2)'(NUMSAMPLES/4 - 1);
    localparam logic [ADDRBITS-1:0] c_LAST_WORD = ADDRBITS'(NUMSAMPLES - 1);

    logic [1:0]          r_state;
    logic [ADDRBITS-3:0] r_wr_ptr;
    logic [ADDRBITS-1:0] r_rd_ptr;
    logic [WORDSIZE-1:0] r_mem [0:NUMSAMPLES-1];
    logic [WORDSIZE-1:0] r_out_data;
    logic                r_out_valid;
    logic                r_wr_done;
    logic                r_wr_error;

    logic [ADDRBITS-1:0] w_rd_sel;
    logic [ADDRBITS-1:0] w_rd_addr;

    // While a word is already presented, prefetch the next one so an accepted
    // word is replaced on the very next cycle.
    assign w_rd_sel = r_out_valid ? (r_rd_ptr + 1'b1) : r_rd_ptr;

    generate
        if (BITREV != 0) begin : g_rev_order
            logic [ADDRBITS-1:0] w_rev;
            for (genvar gi = 0; gi < ADDRBITS; gi++) begin : g_bitrev
                assign w_rev[gi] = w_rd_sel[ADDRBITS-1-gi];
            end
            assign w_rd_addr = w_rev;
        end else begin : g_nat_order
            assign w_rd_addr = w_rd_sel;
        end
    endgenerate

    // Store one four-word result group into consecutive buffer slots
    always_ff @(posedge clk) begin
        if (r_state == c_CAPTURE && bus.in_valid) begin
            r_mem[{r_wr_ptr, 2'd0}] <= bus.fft_out0;
            r_mem[{r_wr_ptr, 2'd1}] <= bus.fft_out1;
            r_mem[{r_wr_ptr, 2'd2}] <= bus.fft_out2;
            r_mem[{r_wr_ptr, 2'd3}] <= bus.fft_out3;
        end
    end

    // Frame sequencing: capture, drain, completion handshake and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_wr_done   <= 1'b0;
            r_wr_error  <= 1'b0;
        end else begin
            // Result data arriving when no frame is being captured is dropped
            if (bus.in_valid && r_state != c_CAPTURE) begin
                r_wr_error <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    if (bus.st_data) begin
                        r_state    <= c_CAPTURE;
                        r_wr_ptr   <= '0;
                        r_rd_ptr   <= '0;
                        r_wr_error <= 1'b0;
                    end
                end
                c_CAPTURE: begin
                    if (!bus.st_data) begin
                        r_state  <= c_IDLE;
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                    end else if (bus.in_valid) begin
                        if (r_wr_ptr == c_LAST_GRP) begin
                            r_state <= c_DRAIN;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
                c_DRAIN: begin
                    if (!bus.st_data) begin
                        r_state     <= c_IDLE;
                        r_out_valid <= 1'b0;
                        r_wr_ptr    <= '0;
                        r_rd_ptr    <= '0;
                    end else if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_mem[w_rd_addr];
                    end else if (bus.out_ready) begin
                        if (r_rd_ptr == c_LAST_WORD) begin
                            r_state     <= c_DONE;
                            r_out_valid <= 1'b0;
                            r_wr_done   <= 1'b1;
                        end else begin
                            r_rd_ptr   <= r_rd_ptr + 1'b1;
                            r_out_data <= r_mem[w_rd_addr];
                        end
                    end
                end
                c_DONE: begin
                    if (!bus.st_data) begin
                        r_state   <= c_IDLE;
                        r_wr_done <= 1'b0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.wr_done   = r_wr_done;
    assign bus.wr_error  = r_wr_error;

endmodule
`default_nettype wire

// File: tb/tb_write_output.sv
`default_nettype none
// ============================================================================
//  Module      : tb_write_output
//  Description : Randomised scoreboard bench for write_output; a natural-order
//                and a bit-reversed instance share the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_write_output;

    localparam int c_N = 32;

    logic        clk;
    logic        rst;
    logic        st_data;
    logic        in_valid;
    logic [15:0] f0, f1, f2, f3;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    int hs0 = 0;
    int hs1 = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    write_output_if #(.WORDSIZE(16)) bus0 ();
    write_output_if #(.WORDSIZE(16)) bus1 ();

    assign bus0.st_data = st_data;  assign bus1.st_data = st_data;
    assign bus0.in_valid = in_valid; assign bus1.in_valid = in_valid;
    assign bus0.fft_out0 = f0; assign bus1.fft_out0 = f0;
    assign bus0.fft_out1 = f1; assign bus1.fft_out1 = f1;
    assign bus0.fft_out2 = f2; assign bus1.fft_out2 = f2;
    assign bus0.fft_out3 = f3; assign bus1.fft_out3 = f3;
    assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;

    write_output #(.WORDSIZE(16), .NUMSAMPLES(32), .ADDRBITS(5), .BITREV(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));
    write_output #(.WORDSIZE(16), .NUMSAMPLES(32), .ADDRBITS(5), .BITREV(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int brev5(input int j);
        int r = 0;
        for (int b = 0; b < 5; b++) if (((j >> b) & 1) != 0) r |= (1 << (4 - b));
        return r;
    endfunction

    function automatic logic rdy(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Scoreboard monitors: pop on every accepted word, check stall stability
    logic        stall0 = 1'b0, stall1 = 1'b0;
    logic [15:0] held0 = '0, held1 = '0;
    always @(negedge clk) begin
        if (!rst && bus0.out_valid && out_ready) begin
            hs0++;
            if (q0.size() == 0) chk("nat_unexpected_word", 32'(bus0.out_data), 32'hDEAD_BEEF);
            else chk("nat_data", 32'(bus0.out_data), 32'(q0.pop_front()));
        end
        if (stall0 && !rst) begin
            chk("nat_stall_valid", 32'(bus0.out_valid), 32'd1);
            chk("nat_stall_data", 32'(bus0.out_data), 32'(held0));
        end
        stall0 = !rst && bus0.out_valid && !out_ready;
        held0  = bus0.out_data;
    end
    always @(negedge clk) begin
        if (!rst && bus1.out_valid && out_ready) begin
            hs1++;
            if (q1.size() == 0) chk("rev_unexpected_word", 32'(bus1.out_data), 32'hDEAD_BEEF);
            else chk("rev_data", 32'(bus1.out_data), 32'(q1.pop_front()));
        end
        if (stall1 && !rst) begin
            chk("rev_stall_valid", 32'(bus1.out_valid), 32'd1);
            chk("rev_stall_data", 32'(bus1.out_data), 32'(held1));
        end
        stall1 = !rst && bus1.out_valid && !out_ready;
        held1  = bus1.out_data;
    end

    // One frame: capture 8 groups (optionally with bubbles), drain with the
    // chosen ready pattern, optionally reset after rst_after accepted words.
    task automatic run_frame(input int rnd_data, input int bubble, input int rmode, input int rst_after);
        logic [15:0] frame [c_N];
        int k, i, cyc, vcyc, base0, base1;
        logic vcap, got_done;
        for (int j = 0; j < c_N; j++) frame[j] = rnd_data ? 16'($urandom) : 16'(j);
        for (int j = 0; j < c_N; j++) begin
            q0.push_back(frame[j]);
            q1.push_back(frame[brev5(j)]);
        end
        base0 = hs0; base1 = hs1;
        tick(); st_data = 1'b1; out_ready = 1'b1;
        tick();
        k = 0; i = 0; vcap = 1'b0;
        while (k < 8) begin
            if (bubble != 0 && (i % 5 == 1 || i % 5 == 4)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                f0 = frame[4*k]; f1 = frame[4*k+1]; f2 = frame[4*k+2]; f3 = frame[4*k+3];
                k++;
            end
            i++;
            tick();
            vcap |= bus0.out_valid | bus1.out_valid;
        end
        in_valid = 1'b0;
        chk("no_valid_during_capture", 32'(vcap), 32'd0);
        @(negedge clk);
        chk("drain_entry_latency", 32'(bus0.out_valid), 32'd0);
        tick();
        out_ready = rdy(rmode, 0);
        @(negedge clk);
        chk("first_valid_nat", 32'(bus0.out_valid), 32'd1);
        chk("first_valid_rev", 32'(bus1.out_valid), 32'd1);
        cyc = 0; vcyc = 0; got_done = 1'b0;
        while (cyc < 300) begin
            if (bus0.out_valid) vcyc++;
            if (bus0.wr_done) begin got_done = 1'b1; break; end
            tick();
            cyc++;
            if (rst_after >= 0 && (hs0 - base0) == rst_after) begin
                rst = 1'b1; out_ready = 1'b0; st_data = 1'b0;
                tick();
                q0.delete(); q1.delete();
                @(negedge clk);
                chk("rst_mid_drain_valid", 32'(bus0.out_valid | bus1.out_valid), 32'd0);
                chk("rst_mid_drain_done", 32'(bus0.wr_done | bus1.wr_done), 32'd0);
                tick();
                rst = 1'b0;
                return;
            end
            out_ready = rdy(rmode, cyc);
            @(negedge clk);
        end
        chk("done_timeout", 32'(got_done), 32'd1);
        chk("done_rev", 32'(bus1.wr_done), 32'd1);
        chk("handshakes_nat", 32'(hs0 - base0), 32'd32);
        chk("handshakes_rev", 32'(hs1 - base1), 32'd32);
        chk("queue_empty", 32'(q0.size() + q1.size()), 32'd0);
        if (rmode == 0) chk("full_throughput_cycles", 32'(vcyc), 32'd32);
        tick();
        chk("done_held", 32'(bus0.wr_done), 32'd1);
        st_data = 1'b0;
        tick();
        @(negedge clk);
        chk("done_cleared", 32'(bus0.wr_done | bus1.wr_done), 32'd0);
        chk("idle_no_valid", 32'(bus0.out_valid | bus1.out_valid), 32'd0);
    endtask

    initial begin
        logic sawv;
        rst = 1'b1; st_data = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        f0 = '0; f1 = '0; f2 = '0; f3 = '0;
        tick(); tick();
        @(negedge clk);
        chk("reset_valid", 32'(bus0.out_valid | bus1.out_valid), 32'd0);
        chk("reset_data", 32'(bus0.out_data | bus1.out_data), 32'd0);
        chk("reset_done", 32'(bus0.wr_done | bus1.wr_done), 32'd0);
        chk("reset_error", 32'(bus0.wr_error | bus1.wr_error), 32'd0);
        tick(); rst = 1'b0;

        run_frame(0, 0, 0, -1);   // ramp data, natural + bit-reversed order
        run_frame(0, 1, 0, -1);   // capture bubbles
        run_frame(1, 0, 1, -1);   // backpressure 1,0,0
        run_frame(1, 1, 2, -1);   // random ready with bubbles

        // Stray input while idle, cleared on next start; then abort mid-capture
        tick(); in_valid = 1'b1; f0 = 16'h1111;
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("error_set", 32'(bus0.wr_error), 32'd1);
        chk("error_set_rev", 32'(bus1.wr_error), 32'd1);
        tick(); st_data = 1'b1;
        tick();
        @(negedge clk);
        chk("error_cleared_on_start", 32'(bus0.wr_error | bus1.wr_error), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick(); in_valid = 1'b1;
            f0 = 16'($urandom); f1 = 16'($urandom); f2 = 16'($urandom); f3 = 16'($urandom);
        end
        tick(); in_valid = 1'b0; st_data = 1'b0; out_ready = 1'b1;
        sawv = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            sawv |= bus0.out_valid | bus1.out_valid | bus0.wr_done;
        end
        chk("abort_no_output", 32'(sawv), 32'd0);
        chk("abort_no_error", 32'(bus0.wr_error), 32'd0);

        run_frame(1, 0, 0, 10);   // reset after 10 accepted words
        run_frame(0, 0, 0, -1);   // fresh frame drains from word 0

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
